// File: rtl/mram_mr5a16a_ctrl.sv
// MR5A16A MRAM pin sequencer: one valid/ready request port in, registered async-SRAM strobes out.
// Optional build macro MRAM_CTRL_PERF_CNT_EN adds accepted-write/read performance counters.
module mram_mr5a16a_ctrl #(
  parameter int ADDR_WIDTH       = 21,
  parameter int DATA_WIDTH       = 16,
  parameter int WR_SETUP_CYCLES  = 1,
  parameter int WR_PULSE_CYCLES  = 3,
  parameter int WR_HOLD_CYCLES   = 2,
  parameter int RD_ACCESS_CYCLES = 7,
  parameter int TURN_CYCLES      = 1
) (
  input  logic                  clk,
  input  logic                  rstnn,
`ifdef MRAM_CTRL_PERF_CNT_EN
  input  logic                  perf_clr,
  output logic [31:0]           perf_wr_cnt,
  output logic [31:0]           perf_rd_cnt,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mram_addr,
  output logic [DATA_WIDTH-1:0] mram_dq_o,
  output logic                  mram_dq_oe,
  input  logic [DATA_WIDTH-1:0] mram_dq_i,
  output logic                  mram_e_b,
  output logic                  mram_w_b,
  output logic                  mram_g_b,
  output logic                  mram_ub_b,
  output logic                  mram_lb_b
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(WR_SETUP_CYCLES, WR_PULSE_CYCLES),
                                     max2(WR_HOLD_CYCLES, RD_ACCESS_CYCLES)),
                                max2(TURN_CYCLES, 1));
  localparam int CW = $clog2(MAX_CYC) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t SETUP_LD = cnt_t'(WR_SETUP_CYCLES - 1);
  localparam cnt_t PULSE_LD = cnt_t'(WR_PULSE_CYCLES - 1);
  localparam cnt_t HOLD_LD  = cnt_t'(WR_HOLD_CYCLES - 1);
  localparam cnt_t RD_LD    = cnt_t'(RD_ACCESS_CYCLES - 1);
  localparam cnt_t TURN_LD  = cnt_t'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);
  localparam cnt_t CNT_ZERO = {CW{1'b0}};
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam bit   HAS_TURN = (TURN_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_SETUP  = 3'd1,
    WR_PULSE  = 3'd2,
    WR_HOLD   = 3'd3,
    RD_ACCESS = 3'd4,
    RSP       = 3'd5,
    TURN      = 3'd6
  } state_t;

  // Read data lanes that were not enabled come back as zero.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [1:0] be);
    return {{(DATA_WIDTH/2){be[1]}}, {(DATA_WIDTH/2){be[0]}}};
  endfunction

  state_t                  state_r;
  cnt_t                    cnt_r;
  logic [1:0]              be_r;
  logic                    req_ready_r;
  logic                    rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   dq_o_r;
  logic                    dq_oe_r;
  logic                    e_b_r;
  logic                    w_b_r;
  logic                    g_b_r;
  logic                    ub_b_r;
  logic                    lb_b_r;
  logic                    cnt_zero_s;

  assign cnt_zero_s = (cnt_r == CNT_ZERO);

  // Sequencer: state, phase counter and every pin register move together.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      be_r        <= 2'b00;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      addr_r      <= {ADDR_WIDTH{1'b0}};
      dq_o_r      <= {DATA_WIDTH{1'b0}};
      dq_oe_r     <= 1'b0;
      e_b_r       <= 1'b1;
      w_b_r       <= 1'b1;
      g_b_r       <= 1'b1;
      ub_b_r      <= 1'b1;
      lb_b_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            be_r <= req_be;
            if (req_be == 2'b00) begin
              // Empty byte mask: no pin activity; a read still owes a zero response.
              if (!req_write) begin
                state_r     <= RSP;
                req_ready_r <= 1'b0;
                rsp_valid_r <= 1'b1;
                rsp_rdata_r <= {DATA_WIDTH{1'b0}};
              end
            end else begin
              req_ready_r <= 1'b0;
              addr_r      <= req_addr;
              e_b_r       <= 1'b0;
              ub_b_r      <= ~req_be[1];
              lb_b_r      <= ~req_be[0];
              if (req_write) begin
                state_r <= WR_SETUP;
                cnt_r   <= SETUP_LD;
                dq_o_r  <= req_wdata;
                dq_oe_r <= 1'b1;
              end else begin
                state_r <= RD_ACCESS;
                cnt_r   <= RD_LD;
                g_b_r   <= 1'b0;
              end
            end
          end
        end
        WR_SETUP: begin
          if (cnt_zero_s) begin
            state_r <= WR_PULSE;
            cnt_r   <= PULSE_LD;
            w_b_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        WR_PULSE: begin
          if (cnt_zero_s) begin
            state_r <= WR_HOLD;
            cnt_r   <= HOLD_LD;
            w_b_r   <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        WR_HOLD: begin
          if (cnt_zero_s) begin
            e_b_r   <= 1'b1;
            ub_b_r  <= 1'b1;
            lb_b_r  <= 1'b1;
            dq_oe_r <= 1'b0;
            if (HAS_TURN) begin
              state_r <= TURN;
              cnt_r   <= TURN_LD;
            end else begin
              state_r     <= IDLE;
              req_ready_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RD_ACCESS: begin
          if (cnt_zero_s) begin
            state_r     <= RSP;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= mram_dq_i & lane_mask(be_r);
            e_b_r       <= 1'b1;
            g_b_r       <= 1'b1;
            ub_b_r      <= 1'b1;
            lb_b_r      <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            if (HAS_TURN && (be_r != 2'b00)) begin
              state_r <= TURN;
              cnt_r   <= TURN_LD;
            end else begin
              state_r     <= IDLE;
              req_ready_r <= 1'b1;
            end
          end
        end
        TURN: begin
          if (cnt_zero_s) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= CNT_ZERO;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          dq_oe_r     <= 1'b0;
          e_b_r       <= 1'b1;
          w_b_r       <= 1'b1;
          g_b_r       <= 1'b1;
          ub_b_r      <= 1'b1;
          lb_b_r      <= 1'b1;
        end
      endcase
    end
  end

`ifdef MRAM_CTRL_PERF_CNT_EN
  logic acc_wr_s;
  logic acc_rd_s;
  logic [31:0] perf_wr_r;
  logic [31:0] perf_rd_r;

  assign acc_wr_s = req_valid && req_ready_r && req_write && (req_be != 2'b00);
  assign acc_rd_s = req_valid && req_ready_r && !req_write && (req_be != 2'b00);

  // Accepted-operation counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      perf_wr_r <= 32'd0;
      perf_rd_r <= 32'd0;
    end else if (perf_clr) begin
      perf_wr_r <= 32'd0;
      perf_rd_r <= 32'd0;
    end else begin
      if (acc_wr_s) perf_wr_r <= perf_wr_r + 32'd1;
      if (acc_rd_s) perf_rd_r <= perf_rd_r + 32'd1;
    end
  end

  assign perf_wr_cnt = perf_wr_r;
  assign perf_rd_cnt = perf_rd_r;
`endif

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign mram_addr  = addr_r;
  assign mram_dq_o  = dq_o_r;
  assign mram_dq_oe = dq_oe_r;
  assign mram_e_b   = e_b_r;
  assign mram_w_b   = w_b_r;
  assign mram_g_b   = g_b_r;
  assign mram_ub_b  = ub_b_r;
  assign mram_lb_b  = lb_b_r;

endmodule

// File: tb/tb_mram_mr5a16a_ctrl.sv
// Bench for mram_mr5a16a_ctrl: behavioural MRAM device, reference memory, response scoreboard
// and pin-timing monitor. Perf counter checks are built when MRAM_CTRL_PERF_CNT_EN is defined.
module tb_mram_mr5a16a_ctrl;
  localparam int AW = 21;
  localparam int DW = 16;
  localparam int S  = 1;
  localparam int P  = 3;
  localparam int H  = 2;
  localparam int RD = 7;
  localparam int T  = 1;

  logic clk = 1'b0;
  logic rstnn;
  logic req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0] req_be;
  logic rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mram_addr;
  logic [DW-1:0] mram_dq_o, mram_dq_i;
  logic mram_dq_oe, mram_e_b, mram_w_b, mram_g_b, mram_ub_b, mram_lb_b;
`ifdef MRAM_CTRL_PERF_CNT_EN
  logic perf_clr;
  logic [31:0] perf_wr_cnt, perf_rd_cnt;
`endif

  mram_mr5a16a_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_SETUP_CYCLES(S), .WR_PULSE_CYCLES(P),
    .WR_HOLD_CYCLES(H), .RD_ACCESS_CYCLES(RD), .TURN_CYCLES(T)
  ) dut (
    .clk(clk), .rstnn(rstnn),
`ifdef MRAM_CTRL_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mram_addr(mram_addr), .mram_dq_o(mram_dq_o), .mram_dq_oe(mram_dq_oe),
    .mram_dq_i(mram_dq_i), .mram_e_b(mram_e_b), .mram_w_b(mram_w_b),
    .mram_g_b(mram_g_b), .mram_ub_b(mram_ub_b), .mram_lb_b(mram_lb_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          acc;
    bit          lat;
  } rsp_t;

  rsp_t        sb[$];
  logic [15:0] mem[64];
  logic [15:0] ref_mem[64];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int exp_wr = 0;
  int exp_rd = 0;
  bit hold_low = 1'b0;
  bit last_wr = 1'b0;

  function automatic logic [5:0] idx(input logic [AW-1:0] a);
    return {a[20], a[4:0]};
  endfunction

  // Device model: drives only enabled lanes, junk elsewhere and when not selected.
  assign mram_dq_i = (!mram_e_b && !mram_g_b) ?
                     {(mram_ub_b ? 8'hEE : mem[idx(mram_addr)][15:8]),
                      (mram_lb_b ? 8'hEE : mem[idx(mram_addr)][7:0])} : 16'hA5A5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Device write commits on the rising edge of W_b while still selected.
  initial forever begin
    @(posedge mram_w_b);
    if (rstnn === 1'b1 && mram_e_b === 1'b0 && mram_dq_oe === 1'b1) begin
      if (!mram_ub_b) mem[idx(mram_addr)][15:8] = mram_dq_o[15:8];
      if (!mram_lb_b) mem[idx(mram_addr)][7:0] = mram_dq_o[7:0];
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pin timing, bus ownership, occupancy and the response scoreboard.
  initial begin
    int e_run, w_run, g_run, w_at, rdy_low;
    bit wrote, prev_rv;
    e_run = 0; w_run = 0; g_run = 0; w_at = 0; rdy_low = 0; wrote = 0; prev_rv = 0;
    forever begin
      @(negedge clk);
      if (rstnn !== 1'b1) begin
        e_run = 0; w_run = 0; g_run = 0; w_at = 0; rdy_low = 0; wrote = 0; prev_rv = 0;
      end else begin
        if (mram_dq_oe) check("g_b_high_while_oe", 32'(mram_g_b), 32'd1);
        if (!mram_e_b) e_run++;
        if (!mram_g_b) g_run++;
        if (!mram_w_b) begin
          if (w_run == 0) w_at = e_run;
          w_run++;
          wrote = 1'b1;
          check("oe_during_pulse", 32'(mram_dq_oe), 32'd1);
        end else if (w_run > 0) begin
          check("w_pulse_len", 32'(w_run), 32'(P));
          check("w_setup_len", 32'(w_at), 32'(S + 1));
          w_run = 0;
        end
        if (mram_e_b && e_run > 0) begin
          if (wrote) check("e_len_write", 32'(e_run), 32'(S + P + H));
          else begin
            check("e_len_read", 32'(e_run), 32'(RD));
            check("g_len_read", 32'(g_run), 32'(RD));
          end
          e_run = 0; g_run = 0; wrote = 1'b0;
        end
        if (!req_ready) rdy_low++;
        else if (rdy_low > 0) begin
          if (last_wr) check("write_occupancy", 32'(rdy_low), 32'(S + P + H + T));
          rdy_low = 0;
        end
        if (rsp_valid) begin
          check("ready_low_in_rsp", 32'(req_ready), 32'd0);
          check("strobes_high_in_rsp", 32'({mram_e_b, mram_g_b, mram_ub_b, mram_lb_b}), 32'hF);
          if (sb.size() == 0) fail("unexpected_rsp");
          else begin
            if (!prev_rv && sb[0].lat) check("read_latency", 32'(cyc - sb[0].acc), 32'(RD + 1));
            check("rsp_rdata", 32'(rsp_rdata), 32'(sb[0].data));
            if (rsp_ready) void'(sb.pop_front());
          end
        end
        prev_rv = rsp_valid;
      end
    end
  end

  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [15:0] d,
                        input logic [1:0] be, input bit upd);
    int   guard;
    rsp_t r;
    guard = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      fail("req_ready_timeout");
      return;
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
    if (upd) begin
      if (wr) begin
        if (be[1]) ref_mem[idx(a)][15:8] = d[15:8];
        if (be[0]) ref_mem[idx(a)][7:0] = d[7:0];
        if (be != 2'b00) exp_wr++;
      end else begin
        r.data = ref_mem[idx(a)] & {{8{be[1]}}, {8{be[0]}}};
        r.acc  = cyc;
        r.lat  = (be != 2'b00);
        sb.push_back(r);
        if (be != 2'b00) exp_rd++;
      end
    end
    @(posedge clk);
    #1;
    last_wr   = wr && (be != 2'b00);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
    req_be    = 2'($urandom);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) fail("drain_timeout");
  endtask

  initial begin
    int g;
    bit wr;
    logic [AW-1:0] a;
    logic [1:0] be;
    rstnn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = 2'b00;
`ifdef MRAM_CTRL_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    repeat (3) @(negedge clk);
    rstnn = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_strobes", 32'({mram_e_b, mram_w_b, mram_g_b, mram_ub_b, mram_lb_b}), 32'h1F);
    check("rst_dq_oe", 32'(mram_dq_oe), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_addr_dq", 32'({mram_addr, mram_dq_o} != '0), 32'd0);

    do_req(1'b1, 21'h00001, 16'h0011, 2'b11, 1'b1);
    do_req(1'b1, 21'h00000, 16'h5544, 2'b11, 1'b1);
    do_req(1'b0, 21'h00000, 16'h0000, 2'b11, 1'b1);
    drain();

    hold_low = 1'b1;
    do_req(1'b0, 21'h00000, 16'h0000, 2'b01, 1'b1);
    g = 0;
    while (rsp_valid !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) fail("rsp_valid_timeout");
    repeat (5) @(negedge clk);
    check("rsp_held_valid", 32'(rsp_valid), 32'd1);
    check("rsp_held_rdata", 32'(rsp_rdata), 32'h0044);
    hold_low = 1'b0;
    drain();

    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = AW'(($urandom_range(0, 1) << 20) | $urandom_range(0, 31));
      be = 2'($urandom_range(0, 3));
      do_req(wr, a, 16'($urandom), be, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    do_req(1'b1, 21'h00003, 16'hBEEF, 2'b11, 1'b0);
    g = 0;
    while (mram_w_b !== 1'b0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) fail("w_b_low_timeout");
    #2 rstnn = 1'b0;
    #1;
    check("async_rst_w_e", 32'({mram_w_b, mram_e_b}), 32'h3);
    check("async_rst_oe", 32'(mram_dq_oe), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd1);
    exp_wr = 0;
    exp_rd = 0;
    repeat (2) @(negedge clk);
    rstnn = 1'b1;
    do_req(1'b1, 21'h00003, 16'h1234, 2'b11, 1'b1);
    do_req(1'b0, 21'h00003, 16'h0000, 2'b11, 1'b1);
    drain();

`ifdef MRAM_CTRL_PERF_CNT_EN
    check("perf_wr_cnt", perf_wr_cnt, 32'(exp_wr));
    check("perf_rd_cnt", perf_rd_cnt, 32'(exp_rd));
    perf_clr = 1'b1;
    do_req(1'b1, 21'h00005, 16'h0F0F, 2'b11, 1'b1);
    perf_clr = 1'b0;
    check("perf_clr_wr", perf_wr_cnt, 32'd0);
    check("perf_clr_rd", perf_rd_cnt, 32'd0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mram_mr5a16a_ctrl.md
Name: mram_mr5a16a_ctrl

Overview:
Synchronous controller that sequences the asynchronous MR5A16A 16-bit MRAM pins (address, DQ, E_b, W_b, G_b, UB_b, LB_b) from a single valid/ready request port. Generates write-pulse and read-access timing with cycle counters and captures read data. Handles bus turnaround. Sits between the system bus bridge and the external MRAM pads.

Parameters:
ADDR_WIDTH, 21, word address width to MRAM
DATA_WIDTH, 16, DQ width (fixed byte lanes: [15:8] UB, [7:0] LB)
WR_SETUP_CYCLES, 1, cycles address/E_b/DQ stable before W_b falls (>=1)
WR_PULSE_CYCLES, 3, cycles W_b held low (>=1)
WR_HOLD_CYCLES, 2, cycles DQ/address held after W_b rises (>=1)
RD_ACCESS_CYCLES, 7, cycles from E_b/G_b low to data capture (>=1)
TURN_CYCLES, 1, idle cycles with all strobes high between operations (>=0)

Ports:
clk  input  1  clock
rstnn  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller accepts request this cycle
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  DATA_WIDTH  write data
req_be  input  2  byte enables, [1]=upper, [0]=lower
rsp_valid  output  1  read data valid
rsp_ready  input  1  consumer accepts read data
rsp_rdata  output  DATA_WIDTH  read data
mram_addr  output  ADDR_WIDTH  MRAM address
mram_dq_o  output  DATA_WIDTH  DQ drive value
mram_dq_oe  output  1  DQ output enable (pad tristate control)
mram_dq_i  input  DATA_WIDTH  DQ sampled value
mram_e_b  output  1  chip enable, active low
mram_w_b  output  1  write enable, active low
mram_g_b  output  1  output enable, active low
mram_ub_b  output  1  upper byte enable, active low
mram_lb_b  output  1  lower byte enable, active low

Behaviour:
- Clock clk; reset rstnn asynchronous, active-low. During/after reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, mram_addr=0, mram_dq_o=0, mram_dq_oe=0, mram_e_b=1, mram_w_b=1, mram_g_b=1, mram_ub_b=1, mram_lb_b=1. All pin outputs are registered.
- Request accepted on req_valid&&req_ready; addr/wdata/be/write latched; req_ready=1 only in IDLE.
- req_be==2'b00: accepted, no pin activity; read still returns rsp with rsp_rdata=0; TURN skipped.
- FSM: IDLE -> WR_SETUP | RD_ACCESS; WR_SETUP -> WR_PULSE -> WR_HOLD -> TURN; RD_ACCESS -> RSP -> TURN; TURN -> IDLE (TURN_CYCLES=0: straight to IDLE).
- WR_SETUP: e_b=0, w_b=1, g_b=1, ub_b/lb_b=~be, dq_oe=1, dq_o=wdata, WR_SETUP_CYCLES.
- WR_PULSE: w_b=0, all else unchanged, WR_PULSE_CYCLES.
- WR_HOLD: w_b=1, e_b=0, dq_oe=1, addr/dq unchanged, WR_HOLD_CYCLES.
- g_b never low while dq_oe=1; dq_oe never 1 while g_b=0.
- RD_ACCESS: e_b=0, g_b=0, w_b=1, dq_oe=0, ub_b/lb_b=~be; mram_dq_i sampled on last cycle of RD_ACCESS_CYCLES; disabled lanes forced to 0 in rsp_rdata.
- RSP: strobes all high; rsp_valid=1, rsp_rdata stable until rsp_ready; leave on rsp_valid&&rsp_ready. rsp_ready already high on entry -> one-cycle RSP.
- TURN: all strobes high, dq_oe=0, TURN_CYCLES.
- Read latency req accept -> rsp_valid = RD_ACCESS_CYCLES+1 cycles. Write occupancy = SETUP+PULSE+HOLD+TURN cycles.
- Cycle counter width clog2(max param)+1; loads (N-1) on state entry, advances at 0.
- req_* changes while busy: ignored. Reset mid-operation: pins immediately return to reset values (write may be partial; no completion guaranteed).

Optional Feature:
MRAM_CTRL_PERF_CNT_EN: defined -> adds outputs perf_wr_cnt[31:0], perf_rd_cnt[31:0] (incremented on accepted write/read with be!=0, wrap at 2^32, reset 0) and input perf_clr (synchronous clear, priority over increment same cycle). Undefined -> ports and counters absent, behaviour otherwise identical.

Test Plan:
- Reset release, idle 10 cycles -> all strobes 1, dq_oe=0, req_ready=1, rsp_valid=0.
- Write addr=0x00001 data=0x0011 be=11 -> e_b low 6 cycles, w_b low exactly 3 cycles starting 1 cycle after e_b, dq_o=0x0011 throughout, req_ready back after 7 cycles.
- Write 0x00000=0x5544, then read 0x00000 with model returning 0x5544 -> rsp_valid 8 cycles after accept, rsp_rdata=0x5544, g_b low 7 cycles, dq_oe=0 throughout read.
- Read be=01 from location holding 0x5544 -> lb_b=0, ub_b=1, rsp_rdata=0x0044; rsp_ready held low 5 cycles -> rsp_valid/rdata stable, no new accept.
- Assert rstnn low during WR_PULSE -> w_b, e_b go 1 and dq_oe 0 without waiting for clk edge; next request proceeds normally.
- With MRAM_CTRL_PERF_CNT_EN: 3 writes, 2 reads, 1 be=00 write -> perf_wr_cnt=3, perf_rd_cnt=2; perf_clr same cycle as an accept -> both 0.
